// File: rtl/cfg_bus_rr_arb.sv
`default_nettype none
// cfg_bus_rr_arb: round-robin arbiter that serializes single-beat cfg accesses from NUM_REQ requesters
// onto one slave port. Define CFG_ARB_TIMEOUT_EN to abort hung transactions with an error response.
module cfg_bus_rr_arb #(
  parameter int          NUM_REQ        = 4,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ*32-1:0]   req_addr_i,
  input  logic [NUM_REQ*32-1:0]   req_wdata_i,
  input  logic [NUM_REQ-1:0]      req_wr_i,
  input  logic [NUM_REQ-1:0]      req_rd_i,
  output logic [NUM_REQ-1:0]      req_ack_o,
  output logic [NUM_REQ-1:0]      req_err_o,
  output logic [31:0]             req_rdata_o,
  output logic [31:0]             cfg_addr_o,
  output logic [31:0]             cfg_wdata_o,
  output logic                    cfg_wr_o,
  output logic                    cfg_rd_o,
  input  logic                    cfg_ack_i,
  input  logic [31:0]             cfg_rdata_i,
  output logic [2:0]              grant_id_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_ACK    = 2'd2
  } state_e;

  state_e               state_q;
  logic [2:0]           grant_q;
  logic [2:0]           last_grant_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic                 wr_q;
  logic                 rd_q;
  logic [31:0]          rdata_q;
  logic [NUM_REQ-1:0]   ack_q;

  logic [7:0]           pending_d;
  logic [3:0]           idx_d;
  logic [2:0]           pick_d;
  logic                 any_d;
  logic [31:0]          sel_addr_d;
  logic [31:0]          sel_wdata_d;
  logic                 sel_wr_d;
  logic [NUM_REQ-1:0]   grant_onehot_d;
  logic                 tmo_hit_d;

  // Search starts one past the last winner and wraps, giving each requester a turn.
  always_comb begin
    pending_d = 8'(req_wr_i | req_rd_i);
    pick_d    = 3'd0;
    any_d     = 1'b0;
    idx_d     = 4'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_d = {1'b0, last_grant_q} + 4'(k);
      if (idx_d >= 4'(NUM_REQ)) begin
        idx_d = idx_d - 4'(NUM_REQ);
      end
      if (!any_d && pending_d[idx_d[2:0]]) begin
        any_d  = 1'b1;
        pick_d = idx_d[2:0];
      end
    end
  end

  always_comb begin
    sel_addr_d  = 32'd0;
    sel_wdata_d = 32'd0;
    sel_wr_d    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_d == 3'(i)) begin
        sel_addr_d  = req_addr_i[i*32 +: 32];
        sel_wdata_d = req_wdata_i[i*32 +: 32];
        sel_wr_d    = req_wr_i[i];
      end
    end
  end

  assign grant_onehot_d = NUM_REQ'(1) << grant_q;

`ifdef CFG_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0]        tmo_cnt_q;
  logic [NUM_REQ-1:0]   err_q;

  // Held at zero outside ACTIVE so it starts cleared on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q != S_ACTIVE) begin
      tmo_cnt_q <= '0;
    end else if (!cfg_ack_i) begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end

  assign tmo_hit_d = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign req_err_o = err_q;
`else
  assign tmo_hit_d = 1'b0 & (TIMEOUT_CYCLES == 0);
  assign req_err_o = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 3'd0;
      last_grant_q <= 3'(NUM_REQ - 1);
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      rdata_q      <= 32'd0;
      ack_q        <= '0;
`ifdef CFG_ARB_TIMEOUT_EN
      err_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_d) begin
            grant_q      <= pick_d;
            last_grant_q <= pick_d;
            addr_q       <= sel_addr_d;
            wdata_q      <= sel_wdata_d;
            // A simultaneous rd+wr is performed as a write.
            wr_q         <= sel_wr_d;
            rd_q         <= ~sel_wr_d;
            state_q      <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (cfg_ack_i) begin
            rdata_q <= cfg_rdata_i;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ack_q   <= grant_onehot_d;
            state_q <= S_ACK;
          end else if (tmo_hit_d) begin
            rdata_q <= ERR_RDATA;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ack_q   <= grant_onehot_d;
`ifdef CFG_ARB_TIMEOUT_EN
            err_q   <= grant_onehot_d;
`endif
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          ack_q   <= '0;
`ifdef CFG_ARB_TIMEOUT_EN
          err_q   <= '0;
`endif
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ack_o   = ack_q;
  assign req_rdata_o = rdata_q;
  assign cfg_addr_o  = addr_q;
  assign cfg_wdata_o = wdata_q;
  assign cfg_wr_o    = wr_q;
  assign cfg_rd_o    = rd_q;
  assign grant_id_o  = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_bus_rr_arb.sv
`default_nettype none
// Bench for cfg_bus_rr_arb: random requesters and slave, scoreboarded against a round-robin reference.
module tb_cfg_bus_rr_arb;
  localparam int          N   = 4;
  localparam int          TMO = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef CFG_ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    req_wr;
  logic [N-1:0]    req_rd;
  logic [N-1:0]    req_ack;
  logic [N-1:0]    req_err;
  logic [31:0]     req_rdata;
  logic [31:0]     cfg_addr;
  logic [31:0]     cfg_wdata;
  logic            cfg_wr;
  logic            cfg_rd;
  logic            cfg_ack;
  logic [31:0]     cfg_rdata;
  logic [2:0]      grant_id;

  cfg_bus_rr_arb #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(TMO),
    .ERR_RDATA     (ERR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_wr_i   (req_wr),
    .req_rd_i   (req_rd),
    .req_ack_o  (req_ack),
    .req_err_o  (req_err),
    .req_rdata_o(req_rdata),
    .cfg_addr_o (cfg_addr),
    .cfg_wdata_o(cfg_wdata),
    .cfg_wr_o   (cfg_wr),
    .cfg_rd_o   (cfg_rd),
    .cfg_ack_i  (cfg_ack),
    .cfg_rdata_i(cfg_rdata),
    .grant_id_o (grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          act[N];
  bit          t_wr[N];
  bit          t_rd[N];
  logic [31:0] t_addr[N];
  logic [31:0] t_wdata[N];
  logic [N-1:0] drv_pend;
  int          cur_winner = 0;
  bit          slave_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic load_req(input int i, input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    act[i] = 1'b1; t_wr[i] = wr; t_rd[i] = rd; t_addr[i] = a; t_wdata[i] = d;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_addr[i*32 +: 32]  = t_addr[i];
      req_wdata[i*32 +: 32] = t_wdata[i];
      req_wr[i] = act[i] & t_wr[i];
      req_rd[i] = act[i] & t_rd[i];
    end
    drv_pend = req_wr | req_rd;
  endtask

  // Requesters drop their request as soon as they see their ack, then may reissue.
  task automatic step(input bit rnd);
    int op;
    @(negedge clk);
    for (int i = 0; i < N; i++) if (req_ack[i]) act[i] = 1'b0;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 2) == 0) begin
          op = int'($urandom_range(0, 7));
          load_req(i, (op < 3) || (op == 7), op >= 3, $urandom, $urandom);
        end
      end
    end
    drive();
  endtask

  task automatic wait_drain();
    bit done;
    bit busy;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      step(1'b0);
      busy = cfg_wr | cfg_rd | (req_ack != '0);
      for (int i = 0; i < N; i++) busy |= act[i];
      done = !busy;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout: got busy want idle (cycle %0d)", cyc);
    end
  endtask

  // Slave: acks after a random wait, sometimes never (timeout build), and throws stray acks when idle.
  initial begin : slave
    int cnt;
    int d;
    int r;
    exp_t e;
    cnt = 0; d = 0;
    cfg_ack = 1'b0; cfg_rdata = 32'd0;
    forever begin
      @(negedge clk);
      cfg_ack = 1'b0;
      if (rst) begin
        cnt = 0;
        continue;
      end
      if (cfg_wr | cfg_rd) begin
        if (cnt == 0) begin
          if (TMO_ON) begin
            r = int'($urandom_range(0, 9));
            d = (r < 7) ? r % 5 : (r == 7) ? TMO - 1 : TMO + 3;
          end else begin
            d = int'($urandom_range(0, 4));
          end
          if (TMO_ON && !slave_hold && d >= TMO) begin
            e.id = cur_winner; e.rdata = ERR; e.err = 1'b1; e.cyc = cyc + TMO;
            exp_q.push_back(e);
          end
        end
        if (!slave_hold && cnt == d && d < TMO) begin
          cfg_ack   = 1'b1;
          cfg_rdata = $urandom;
          e.id = cur_winner; e.rdata = cfg_rdata; e.err = 1'b0; e.cyc = cyc + 1;
          exp_q.push_back(e);
        end
        cnt++;
      end else begin
        cnt = 0;
        if (!slave_hold && $urandom_range(0, 7) == 0) begin
          cfg_ack   = 1'b1;
          cfg_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: round-robin reference for grants, scoreboard for completions.
  initial begin : monitor
    int   last;
    int   w;
    int   idx;
    bit   prev_idle;
    bit   prev_strobe;
    bit   strobe;
    exp_t e;
    last = N - 1; prev_idle = 1'b1; prev_strobe = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last = N - 1; prev_idle = 1'b1; prev_strobe = 1'b0;
        exp_q.delete();
        continue;
      end
      strobe = cfg_wr | cfg_rd;
      if (req_ack != '0) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack: got %h want none (cycle %0d)", req_ack, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("ack_onehot", 32'(req_ack), 32'(1) << e.id);
          chk("ack_rdata", req_rdata, e.rdata);
          chk("ack_err", 32'(req_err), e.err ? (32'(1) << e.id) : 32'd0);
          chk("ack_cycle", cyc, e.cyc);
        end
      end else begin
        chk("err_idle", 32'(req_err), 32'd0);
      end
      if (prev_idle) chk("start_after_idle", 32'(strobe), 32'(drv_pend != '0));
      if (strobe && !prev_strobe && drv_pend != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          idx = (last + k) % N;
          if (w < 0 && drv_pend[idx]) w = idx;
        end
        chk("grant_id", 32'(grant_id), w);
        chk("cfg_addr", cfg_addr, t_addr[w]);
        chk("cfg_wdata", cfg_wdata, t_wdata[w]);
        chk("cfg_wr", 32'(cfg_wr), 32'(t_wr[w]));
        chk("cfg_rd", 32'(cfg_rd), 32'(t_rd[w] & ~t_wr[w]));
        last = w;
        cur_winner = w;
      end
      prev_idle   = !strobe && (req_ack == '0);
      prev_strobe = strobe;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    for (int i = 0; i < N; i++) load_req(i, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    drive();
    #1;
    chk("reset_ack", 32'(req_ack), 32'd0);
    chk("reset_strobe", 32'({cfg_wr, cfg_rd}), 32'd0);
    chk("reset_grant", 32'(grant_id), 32'd0);
    chk("reset_rdata", req_rdata, 32'd0);
    repeat (3) @(negedge clk);

    // All four write from reset, then 0 and 3 re-request.
    rst = 1'b0;
    for (int i = 0; i < N; i++) load_req(i, 1'b1, 1'b0, 32'h100 * (i + 1), $urandom);
    drive();
    wait_drain();
    @(negedge clk);
    load_req(0, 1'b0, 1'b1, 32'h40, 32'd0);
    load_req(3, 1'b1, 1'b0, 32'h4C, 32'hCAFE_0003);
    drive();
    wait_drain();

    for (int s = 0; s < 1500; s++) step(1'b1);
    wait_drain();

    // Reset while a read is stalled in ACTIVE.
    slave_hold = 1'b1;
    @(negedge clk);
    load_req(2, 1'b0, 1'b1, 32'h40, 32'd0);
    drive();
    n = 0;
    while (!cfg_rd && n < 10) begin
      step(1'b0);
      n++;
    end
    chk("rd_before_reset", 32'(cfg_rd), 32'd1);
    step(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_err", 32'(req_err), 32'd0);
    chk("rst_rdata", req_rdata, 32'd0);
    chk("rst_cfg_addr", cfg_addr, 32'd0);
    chk("rst_cfg_wdata", cfg_wdata, 32'd0);
    chk("rst_strobe", 32'({cfg_wr, cfg_rd}), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    drive();
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_ack", 32'(req_ack), 32'd0);
    end
    rst = 1'b0;
    slave_hold = 1'b0;
    for (int i = 0; i < N; i++) load_req(i, 1'b0, 1'b1, 32'h200 + 32'(i), 32'd0);
    drive();
    wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cfg_bus_rr_arb.md
# cfg_bus_rr_arb

Round-robin arbiter that shares one downstream `cfg_bus_t` register port among NUM_REQ upstream requesters, e.g. the host AXI-Lite bridge, the debug block and the DMA setup engine contending for the same CL register space. It serializes single-beat read/write transactions, returns read data and acknowledges only to the granted requester, and optionally aborts hung transactions with an error response.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 256: cycles to wait for `cfg_ack` before aborting; used only with CFG_ARB_TIMEOUT_EN.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out transaction.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  sole clock.
  - rst  in  1  asynchronous, active-high reset.
- Requester side (flattened, requester i occupies slice i):
  - req_addr  in  NUM_REQ*32  per-requester address.
  - req_wdata  in  NUM_REQ*32  per-requester write data.
  - req_wr  in  NUM_REQ  write request; level, held until ack.
  - req_rd  in  NUM_REQ  read request; level, held until ack.
  - req_ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
  - req_err  out  NUM_REQ  timeout flag, valid with req_ack.
  - req_rdata  out  32  shared read data, valid with req_ack.
- Slave side:
  - cfg_addr  out  32  address to slave.
  - cfg_wdata  out  32  write data to slave.
  - cfg_wr  out  1  write strobe to slave.
  - cfg_rd  out  1  read strobe to slave.
  - cfg_ack  in  1  slave completion.
  - cfg_rdata  in  32  slave read data, valid with cfg_ack.
- grant_id  out  3  index of current/last granted requester (debug).

## Operation
- FSM states IDLE, ACTIVE, ACK.
- IDLE: pending[i] = req_wr[i] | req_rd[i].
  - If any requester is pending, pick the first pending index searching from (last_grant+1) mod NUM_REQ upward, wrapping.
  - Register addr, wdata, op and grant_id; update last_grant; go to ACTIVE.
- ACTIVE: cfg_wr or cfg_rd is held high (registered) together with stable cfg_addr/cfg_wdata.
  - On cfg_ack: capture cfg_rdata into req_rdata, deassert cfg_wr/cfg_rd, go to ACK.
- ACK: req_ack[grant_id] high for exactly this cycle; req_rdata is valid; then go to IDLE.
  - The requester must drop wr/rd on the edge that samples req_ack. The arbiter never re-samples a request before that edge.
- Both req_wr[i] and req_rd[i] high: protocol violation. A write is performed; the rd is consumed by the same ack.
- Requester dropping its request while in ACTIVE: the transaction still completes and req_ack still pulses.
- cfg_ack while in IDLE or ACK: ignored; no state change.
- req_rdata holds its last value outside ACK; for writes it holds cfg_rdata as sampled with cfg_ack.

## Timing
- Reset values:
  - All outputs are 0: req_ack, req_err, req_rdata, cfg_*, grant_id.
  - FSM = IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
- Latency:
  - Request seen in IDLE at cycle 0 → cfg_wr/rd high at cycle 1.
  - cfg_ack at cycle k≥1 → req_ack at cycle k+1 → IDLE at k+2 → next cfg strobe at k+3.
  - Best-case throughput is one transaction per 3 cycles.
- cfg_ack may arrive in the first cycle of ACTIVE (cycle 1).
- Starvation bound: a held request is granted within NUM_REQ-1 intervening transactions.
- Reset mid-transaction: everything returns to reset values immediately (async). No ack is issued for the aborted transaction, and cfg_wr/rd drop without an ack.

## Configuration
- CFG_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to ACTIVE and increments each ACTIVE cycle without cfg_ack.
  - When it reaches TIMEOUT_CYCLES, drop cfg_wr/rd and go to ACK, with req_err[grant_id]=1 and req_rdata=ERR_RDATA.
  - cfg_ack in the expiry cycle wins: normal completion, no error.
  - A late cfg_ack after abort is ignored; its misattribution to a following transaction is a slave fault.
- CFG_ARB_TIMEOUT_EN undefined: no counter is built, req_err is tied to 0, and ACTIVE waits indefinitely.

## Test plan
- Single read: req_rd[2]=1, addr 0x40; slave acks 3 cycles after cfg_rd with 0x1234_5678 → cfg_rd high cycle 1..4, req_ack[2] pulse at cycle 5, req_rdata=0x1234_5678, req_err=0.
- All 4 requesters hold writes from reset → grant order 0,1,2,3. Then requesters 0 and 3 re-request → order 0,3. Each cfg_addr matches its source.
- Zero-wait slave (cfg_ack in first ACTIVE cycle), back-to-back requests → new cfg strobe every 3rd cycle, exactly one req_ack per transaction.
- Timeout (TIMEOUT_CYCLES=16, macro on), slave never acks → cfg_rd drops after 16 cycles; req_ack+req_err pulse with rdata 0xDEAD_BEEF. Ack in cycle 16 → no error.
- rst asserted while in ACTIVE → all outputs 0 same cycle, no req_ack. After release, requester 0 gets priority.
